uart_transceiver: RTL and testbench



---
 rtl/uart_transceiver.sv | 178 +++++++++++++++++
 tb/tb_uart_transceiver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transceiver.sv
// 8N1 UART transmitter and receiver sharing one runtime divisor, 16x oversampled.
// The RX tick runs freely; the TX tick restarts with each frame so every bit is exactly 16*divisor clocks.
module uart_transceiver (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    input  logic [15:0] divisor,
    output logic [7:0]  rx_data,
    input  logic [7:0]  tx_data,
    output logic        rx_done,
    output logic        tx_done,
    input  logic        tx_wr
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

    logic [15:0] reload;
    assign reload = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;

    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic        rx_tick;
    logic        sync1_q, sync2_q;
    rx_state_t   rx_state_q, rx_state_d;
    logic [3:0]  rx_tcnt_q, rx_tcnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_done_q, rx_done_d;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic        tx_tick;
    logic [3:0]  tx_tcnt_q, tx_tcnt_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [8:0]  tx_sh_q, tx_sh_d;
    logic        uart_tx_q, uart_tx_d;
    logic        tx_done_q, tx_done_d;

    always_comb begin
        rx_tick  = (rx_cnt_q == 16'd0);
        rx_cnt_d = rx_tick ? reload : rx_cnt_q - 16'd1;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        if (rx_tick) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!sync2_q) begin
                        rx_state_d = RX_START;
                        rx_tcnt_d  = 4'd0;
                    end
                end
                RX_START: begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    // Eighth tick lands mid start bit: a high line here was only a glitch.
                    if (rx_tcnt_q == 4'd7) begin
                        rx_tcnt_d  = 4'd0;
                        rx_bit_d   = 3'd0;
                        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    end
                end
                RX_STOP: begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == 4'd15) begin
                        rx_state_d = RX_IDLE;
                        if (sync2_q) begin
                            rx_data_d = rx_sh_q;
                            rx_done_d = 1'b1;
                        end
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        uart_tx_d  = uart_tx_q;
        tx_done_d  = 1'b0;
        tx_tick    = (tx_cnt_q == 16'd0);
        case (tx_state_q)
            TX_IDLE: begin
                uart_tx_d = 1'b1;
                if (tx_wr) begin
                    tx_state_d = TX_BUSY;
                    tx_cnt_d   = reload;
                    tx_tcnt_d  = 4'd0;
                    tx_bit_d   = 4'd0;
                    tx_sh_d    = {1'b1, tx_data};
                    uart_tx_d  = 1'b0;
                end
            end
            TX_BUSY: begin
                tx_cnt_d = tx_tick ? reload : tx_cnt_q - 16'd1;
                if (tx_tick) begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                    // tx_bit_q: 0 = start, 1..8 = data, 9 = stop.
                    if (tx_tcnt_q == 4'd15) begin
                        if (tx_bit_q == 4'd9) begin
                            tx_state_d = TX_IDLE;
                            tx_done_d  = 1'b1;
                            uart_tx_d  = 1'b1;
                        end else begin
                            uart_tx_d = tx_sh_q[0];
                            tx_sh_d   = {1'b1, tx_sh_q[8:1]};
                            tx_bit_d  = tx_bit_q + 4'd1;
                        end
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_cnt_q   <= 16'd0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_data_q  <= 8'h00;
            rx_done_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_tcnt_q  <= 4'd0;
            tx_bit_q   <= 4'd0;
            uart_tx_q  <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            sync1_q    <= uart_rx;
            sync2_q    <= sync1_q;
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            uart_tx_q  <= uart_tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        rx_sh_q <= rx_sh_d;
        tx_sh_q <= tx_sh_d;
    end

    assign uart_tx = uart_tx_q;
    assign rx_data = rx_data_q;
    assign rx_done = rx_done_q;
    assign tx_done = tx_done_q;
endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: frame-level TX waveform model, RX byte scoreboard, directed and random frames.
module tb_uart_transceiver;
    logic        clk = 1'b0;
    logic        sys_rst, tx_wr, rx_drv, loop_en;
    logic [15:0] divisor;
    logic [7:0]  tx_data, rx_data;
    logic        uart_tx, rx_done, tx_done, rx_line;

    assign rx_line = loop_en ? uart_tx : rx_drv;
    always #5 clk = ~clk;

    uart_transceiver dut (
        .sys_clk(clk), .sys_rst(sys_rst), .uart_rx(rx_line), .uart_tx(uart_tx),
        .divisor(divisor), .rx_data(rx_data), .tx_data(tx_data), .rx_done(rx_done),
        .tx_done(tx_done), .tx_wr(tx_wr)
    );

    int         n_checks = 0, n_err = 0;
    int         rx_pulses = 0, tx_pulses = 0;
    logic [7:0] exp_rx = 8'h00, pend_rx = 8'h00;
    logic       pend_valid = 1'b0;

    // Inputs as the DUT saw them at the last rising edge.
    logic        rst_s, wr_s;
    logic [7:0]  data_s;
    logic [15:0] div_s;
    always @(posedge clk) begin
        rst_s  <= sys_rst;
        wr_s   <= tx_wr;
        data_s <= tx_data;
        div_s  <= divisor;
    end

    function automatic int deff(input logic [15:0] d);
        return (d == 16'd0) ? 1 : int'(d);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // TX model: after the accepting edge A, edge A+j shows bit j/(16d) of {stop,data,start};
    // edge A+160d raises tx_done and frees the transmitter.
    initial begin : compare
        logic       m_valid, m_busy, exp_tx, exp_done, prev_rx_done;
        int         m_j, m_d;
        logic [9:0] m_frame;
        m_valid = 1'b0; m_busy = 1'b0; exp_tx = 1'b1; exp_done = 1'b0; prev_rx_done = 1'b0;
        m_j = 0; m_d = 1; m_frame = '1;
        forever begin
            @(negedge clk);
            if (rst_s === 1'b1) begin
                m_valid = 1'b1; m_busy = 1'b0; exp_tx = 1'b1; exp_done = 1'b0;
            end else if (m_valid) begin
                exp_done = 1'b0;
                if (m_busy) begin
                    m_j++;
                    if (m_j == 160 * m_d) begin
                        exp_done = 1'b1; m_busy = 1'b0; exp_tx = 1'b1;
                    end else begin
                        exp_tx = m_frame[m_j / (16 * m_d)];
                    end
                end else if (wr_s === 1'b1) begin
                    m_busy = 1'b1; m_j = 0; m_d = deff(div_s);
                    m_frame = {1'b1, data_s, 1'b0}; exp_tx = 1'b0;
                end else begin
                    exp_tx = 1'b1;
                end
            end
            if (m_valid) begin
                chk("uart_tx", 32'(uart_tx), 32'(exp_tx));
                chk("tx_done", 32'(tx_done), 32'(exp_done));
                if (tx_done === 1'b1) tx_pulses++;
                if (rx_done === 1'b1) begin
                    rx_pulses++;
                    chk("rx_done_width", 32'(prev_rx_done), 32'd0);
                    chk("rx_done_expected", 32'(pend_valid), 32'd1);
                    chk("rx_data_on_done", 32'(rx_data), 32'(pend_rx));
                end else begin
                    n_checks++;
                    if (rx_data !== exp_rx && !(pend_valid && rx_data === pend_rx)) begin
                        n_err++;
                        $display("FAIL rx_data_hold: actual=0x%0h required=0x%0h at t=%0t",
                                 rx_data, exp_rx, $time);
                    end
                end
                prev_rx_done = rx_done;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_rx(input logic v, input int n);
        rx_drv = v;
        tick(n);
    endtask

    task automatic send_tx(input logic [7:0] b);
        @(posedge clk); #1 tx_wr = 1'b1; tx_data = b;
        @(posedge clk); #1 tx_wr = 1'b0; tx_data = 8'($urandom);
    endtask

    task automatic wait_tx_done(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_done !== 1'b1 && n < bound);
        chk("tx_done_arrives", 32'(tx_done), 32'd1);
        #1;
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_ok);
        int         bt, n0;
        logic [9:0] fr;
        bt = 16 * deff(divisor);
        n0 = rx_pulses;
        fr = {stop_ok, b, 1'b0};
        if (stop_ok) begin pend_rx = b; pend_valid = 1'b1; end
        for (int i = 0; i < 10; i++) hold_rx(fr[i], bt);
        hold_rx(1'b1, 2 * bt);
        chk("rx_frame_count", 32'(rx_pulses - n0), stop_ok ? 32'd1 : 32'd0);
        chk("rx_frame_data", 32'(rx_data), stop_ok ? 32'(b) : 32'(exp_rx));
        if (stop_ok) exp_rx = b;
        pend_valid = 1'b0;
    endtask

    task automatic send_loop(input logic [7:0] b);
        int n0 = rx_pulses;
        pend_rx = b; pend_valid = 1'b1;
        send_tx(b);
        wait_tx_done(200 * deff(divisor));
        chk("loop_count", 32'(rx_pulses - n0), 32'd1);
        chk("loop_data", 32'(rx_data), 32'(b));
        exp_rx = b; pend_valid = 1'b0;
    endtask

    initial begin : stim
        int         j, done_j, n0, t0;
        logic [9:0] bits;
        sys_rst = 1'b1; tx_wr = 1'b0; tx_data = 8'h00; rx_drv = 1'b1; loop_en = 1'b0;
        divisor = 16'd2;
        tick(4);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_rx_done", 32'(rx_done), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        sys_rst = 1'b0;
        tick(40);

        // 0xA5 at divisor 2: mid-bit samples and done latency counted from the accepting edge
        @(posedge clk); #1 tx_wr = 1'b1; tx_data = 8'hA5;
        @(posedge clk); #1 tx_wr = 1'b0; tx_data = 8'h00;
        j = 0; done_j = -1; bits = '0;
        while (j < 1000 && done_j < 0) begin
            @(negedge clk);
            if (j % 32 == 16 && j < 320) bits[j / 32] = uart_tx;
            if (tx_done === 1'b1) done_j = j;
            else begin @(posedge clk); j++; end
        end
        chk("a5_bits", 32'(bits), 32'b1101001010);
        chk("a5_done_latency", 32'(done_j), 32'd320);
        tick(2);
        chk("a5_idle_after", 32'(uart_tx), 32'd1);

        divisor = 16'd27; loop_en = 1'b1; tick(64);
        send_loop(8'h3C);
        chk("loop_3c_literal", 32'(rx_data), 32'h3C);
        tick(16);
        send_loop(8'hFF);
        chk("loop_ff_literal", 32'(rx_data), 32'hFF);
        loop_en = 1'b0;

        divisor = 16'd4; tick(64);
        n0 = rx_pulses;
        hold_rx(1'b0, 8);
        hold_rx(1'b1, 400);
        chk("glitch_no_done", 32'(rx_pulses - n0), 32'd0);
        chk("glitch_rx_data", 32'(rx_data), 32'hFF);
        drive_rx_frame(8'h55, 1'b0);
        drive_rx_frame(8'h81, 1'b1);
        chk("frame_81_literal", 32'(rx_data), 32'h81);

        // 0x34 mid-frame is dropped; 0x34 on the tx_done cycle goes out back-to-back
        divisor = 16'd2; loop_en = 1'b1; tick(64);
        t0 = tx_pulses; n0 = rx_pulses;
        pend_rx = 8'h12; pend_valid = 1'b1;
        send_tx(8'h12);
        tick(100);
        tx_wr = 1'b1; tx_data = 8'h34; tick(1); tx_wr = 1'b0;
        wait_tx_done(1000);
        chk("midframe_one_done", 32'(tx_pulses - t0), 32'd1);
        chk("first_byte_12", 32'(rx_data), 32'h12);
        exp_rx = 8'h12; pend_rx = 8'h34;
        tx_wr = 1'b1; tx_data = 8'h34; tick(1); tx_wr = 1'b0;
        wait_tx_done(1000);
        chk("b2b_tx_count", 32'(tx_pulses - t0), 32'd2);
        chk("b2b_rx_count", 32'(rx_pulses - n0), 32'd2);
        chk("second_byte_34", 32'(rx_data), 32'h34);
        exp_rx = 8'h34; pend_valid = 1'b0;
        loop_en = 1'b0; tick(40);

        // reset in the middle of a TX frame and an RX frame
        n0 = rx_pulses; t0 = tx_pulses;
        send_tx(8'h77);
        hold_rx(1'b0, 32); hold_rx(1'b1, 32); hold_rx(1'b0, 32);
        sys_rst = 1'b1; tick(1);
        sys_rst = 1'b0; rx_drv = 1'b1; exp_rx = 8'h00; pend_valid = 1'b0;
        chk("rst_mid_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_mid_rx_data", 32'(rx_data), 32'h00);
        tick(400);
        chk("rst_no_rx_done", 32'(rx_pulses - n0), 32'd0);
        chk("rst_no_tx_done", 32'(tx_pulses - t0), 32'd0);

        for (int k = 0; k < 8; k++) begin
            divisor = 16'($urandom_range(1, 3)); tick(8);
            drive_rx_frame(8'($urandom), ($urandom_range(0, 4) != 0));
            hold_rx(1'b1, int'($urandom_range(0, 40)));
        end

        loop_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            divisor = 16'($urandom_range(0, 3)); tick(8);
            send_loop(8'($urandom));
            tick(int'($urandom_range(1, 20)));
        end
        loop_en = 1'b0;

        tick(10);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "time limit");
    end
endmodule
